// File: rtl/cache_2way_wb_if.sv
// CPU load/store and data-memory valid/ready handshake bundle for cache_2way_wb.
// slave is the cache's view; master is the CPU plus memory environment around it.
interface cache_2way_wb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_req_row;
    logic              cpu_req_valid;
    logic [DATA_W-1:0] cpu_data_write;
    logic [DATA_W-1:0] cpu_data_read;
    logic              cpu_ready;

    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_row;
    logic              mem_req_valid;
    logic [DATA_W-1:0] mem_data_write;
    logic [DATA_W-1:0] mem_data_read;
    logic              mem_ready;

    modport slave (
        input  cpu_req_addr, cpu_req_row, cpu_req_valid, cpu_data_write,
        input  mem_data_read, mem_ready,
        output cpu_data_read, cpu_ready,
        output mem_req_addr, mem_req_row, mem_req_valid, mem_data_write
    );

    modport master (
        output cpu_req_addr, cpu_req_row, cpu_req_valid, cpu_data_write,
        output mem_data_read, mem_ready,
        input  cpu_data_read, cpu_ready,
        input  mem_req_addr, mem_req_row, mem_req_valid, mem_data_write
    );
endinterface

// File: rtl/cache_2way_wb.sv
// Write-back, write-allocate cache with 1 or 2 ways and LRU replacement between a
// CPU load/store port and word-addressed memory; counts completed hits and misses.
module cache_2way_wb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 3,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    cache_2way_wb_if.slave   bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("cache_2way_wb: WAYS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic              r_row;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_valid;
    logic              r_mem_row;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic              r_victim;

    logic [DATA_W-1:0] r_data  [WAYS][SETS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [WAYS-1:0]    w_match;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_hit_done;
    logic               w_victim;
    logic               w_victim_dirty;
    logic               w_mem_done;
    logic [SETS-1:0]    w_lru;

    assign w_idx      = r_addr[INDEX_W-1:0];
    assign w_tag      = r_addr[ADDR_W-1:INDEX_W];
    assign w_mem_done = r_mem_valid && bus.mem_ready;

    for (genvar g = 0; g < WAYS; g++) begin : g_match
        assign w_match[g] = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
    end

    assign w_hit      = |w_match;
    assign w_hit_way  = (WAYS == 2) ? w_match[WAYS-1] : 1'b0;
    assign w_hit_done = (r_state == S_COMPARE) && w_hit;

    // Victim: lowest invalid way first, otherwise the set's LRU pointer.
    always_comb begin
        w_victim = 1'b0;
        if (WAYS == 2 && r_valid[0][w_idx]) begin
            if (!r_valid[WAYS-1][w_idx]) w_victim = 1'b1;
            else                         w_victim = w_lru[w_idx];
        end
    end

    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] r_lru;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_lru <= '0;
            end else if (w_hit_done) begin
                r_lru[w_idx] <= ~w_hit_way;
            end
        end

        assign w_lru = r_lru;
    end else begin : g_no_lru
        assign w_lru = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req_valid && !r_cpu_ready) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (w_hit)               w_next = S_IDLE;
                else if (w_victim_dirty) w_next = S_WRITEBACK;
                else                     w_next = S_ALLOCATE;
            end
            S_WRITEBACK: begin
                if (w_mem_done) w_next = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (w_mem_done) w_next = S_COMPARE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr      <= '0;
            r_row       <= 1'b0;
            r_wdata     <= '0;
            r_cpu_ready <= 1'b0;
            r_rdata     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_row   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_victim    <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req_valid && !r_cpu_ready) begin
                        r_addr  <= bus.cpu_req_addr;
                        r_row   <= bus.cpu_req_row;
                        r_wdata <= bus.cpu_data_write;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        r_cpu_ready <= 1'b1;
                        if (!r_row) r_rdata <= r_data[w_hit_way][w_idx];
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                    end else begin
                        // The re-compare after a fill always hits, so only first compares land here.
                        r_victim    <= w_victim;
                        r_mem_valid <= 1'b1;
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        if (w_victim_dirty) begin
                            r_mem_row   <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][w_idx], w_idx};
                            r_mem_wdata <= r_data[w_victim][w_idx];
                        end else begin
                            r_mem_row  <= 1'b0;
                            r_mem_addr <= r_addr;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (w_mem_done) r_mem_valid <= 1'b0;
                end
                S_ALLOCATE: begin
                    // After a write-back, valid stays low one cycle before the fill request.
                    if (w_mem_done) begin
                        r_mem_valid <= 1'b0;
                    end else if (!r_mem_valid) begin
                        r_mem_valid <= 1'b1;
                        r_mem_row   <= 1'b0;
                        r_mem_addr  <= r_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '{default: '0};
            r_dirty <= '{default: '0};
        end else begin
            case (r_state)
                S_COMPARE: begin
                    if (w_hit && r_row) r_dirty[w_hit_way][w_idx] <= 1'b1;
                end
                S_WRITEBACK: begin
                    if (w_mem_done) r_dirty[r_victim][w_idx] <= 1'b0;
                end
                S_ALLOCATE: begin
                    if (w_mem_done) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hit_done && r_row) begin
            r_data[w_hit_way][w_idx] <= r_wdata;
        end else if (r_state == S_ALLOCATE && w_mem_done) begin
            r_data[r_victim][w_idx] <= bus.mem_data_read;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

    assign bus.cpu_data_read  = r_rdata;
    assign bus.cpu_ready      = r_cpu_ready;
    assign bus.mem_req_addr   = r_mem_addr;
    assign bus.mem_req_row    = r_mem_row;
    assign bus.mem_req_valid  = r_mem_valid;
    assign bus.mem_data_write = r_mem_wdata;
    assign hit_count          = r_hit_cnt;
    assign miss_count         = r_miss_cnt;
endmodule

// File: tb/tb_cache_2way_wb.sv
// Bench for cache_2way_wb: directed table on a 2-way instance, reset-mid-miss and
// 1-way eviction sequences, then random traffic against a flat-memory LRU model.
module tb_cache_2way_wb;
    typedef struct {
        logic [7:0]  addr;
        logic        row;
        logic [31:0] data;
    } mop_t;

    typedef struct {
        logic [7:0]  addr;
        logic        row;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_hits;
        int          exp_miss;
        int          exp_ops;
        logic [7:0]  wb_addr;
        logic [31:0] wb_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn0, rstn1;
    logic [15:0] hc0, mc0, hc1, mc1;

    cache_2way_wb_if #(.ADDR_W(8), .DATA_W(32)) b0 ();
    cache_2way_wb_if #(.ADDR_W(8), .DATA_W(32)) b1 ();

    cache_2way_wb #(.ADDR_W(8), .DATA_W(32), .INDEX_W(3), .WAYS(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rstn(rstn0), .bus(b0), .hit_count(hc0), .miss_count(mc0)
    );
    cache_2way_wb #(.ADDR_W(8), .DATA_W(32), .INDEX_W(4), .WAYS(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rstn(rstn1), .bus(b1), .hit_count(hc1), .miss_count(mc1)
    );

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    mop_t        log0 [$];
    mop_t        log1 [$];
    bit          hold0;
    int          checks;
    int          errors;

    function automatic logic [31:0] mem_init(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, a ^ 8'hC3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory for the 2-way instance; hold0 withholds mem_ready.
    initial begin
        mop_t m;
        int d;
        b0.mem_ready = 1'b0;
        b0.mem_data_read = '0;
        forever begin
            @(posedge clk); #1;
            if (b0.mem_req_valid) begin
                d = $urandom_range(0, 3);
                repeat (d) begin @(posedge clk); #1; end
                while (hold0 && b0.mem_req_valid) begin @(posedge clk); #1; end
                if (!b0.mem_req_valid) continue;
                m.addr = b0.mem_req_addr;
                m.row  = b0.mem_req_row;
                if (m.row) begin
                    m.data = b0.mem_data_write;
                    mem0[m.addr] = m.data;
                end else begin
                    m.data = mem0[m.addr];
                    b0.mem_data_read = m.data;
                end
                log0.push_back(m);
                b0.mem_ready = 1'b1;
                @(posedge clk); #1;
                b0.mem_ready = 1'b0;
            end
        end
    end

    initial begin
        mop_t m;
        int d;
        b1.mem_ready = 1'b0;
        b1.mem_data_read = '0;
        forever begin
            @(posedge clk); #1;
            if (b1.mem_req_valid) begin
                d = $urandom_range(0, 3);
                repeat (d) begin @(posedge clk); #1; end
                if (!b1.mem_req_valid) continue;
                m.addr = b1.mem_req_addr;
                m.row  = b1.mem_req_row;
                if (m.row) begin
                    m.data = b1.mem_data_write;
                    mem1[m.addr] = m.data;
                end else begin
                    m.data = mem1[m.addr];
                    b1.mem_data_read = m.data;
                end
                log1.push_back(m);
                b1.mem_ready = 1'b1;
                @(posedge clk); #1;
                b1.mem_ready = 1'b0;
            end
        end
    end

    // Issue one request; inputs are scrambled after acceptance to show they are ignored.
    task automatic do_req(input int sel, input logic [7:0] addr, input logic row,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        bit rdy;
        if (sel == 0) begin
            b0.cpu_req_addr = addr; b0.cpu_req_row = row; b0.cpu_data_write = wd; b0.cpu_req_valid = 1'b1;
        end else begin
            b1.cpu_req_addr = addr; b1.cpu_req_row = row; b1.cpu_data_write = wd; b1.cpu_req_valid = 1'b1;
        end
        lat = 0;
        rd  = '0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                if (sel == 0) begin
                    b0.cpu_req_valid = 1'b0; b0.cpu_req_addr = ~addr; b0.cpu_req_row = ~row; b0.cpu_data_write = ~wd;
                end else begin
                    b1.cpu_req_valid = 1'b0; b1.cpu_req_addr = ~addr; b1.cpu_req_row = ~row; b1.cpu_data_write = ~wd;
                end
            end
            rdy = (sel == 0) ? b0.cpu_ready : b1.cpu_ready;
            if (rdy) begin
                rd = (sel == 0) ? b0.cpu_data_read : b1.cpu_data_read;
                break;
            end
            if (lat >= 300) begin
                checks++;
                errors++;
                $display("FAIL req_timeout: no cpu_ready after %0d cycles, required within 300", lat);
                lat = -1;
                break;
            end
        end
    endtask

    vec_t        vecs [10];
    logic [31:0] rd;
    int          lat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        hold0  = 1'b0;
        b0.cpu_req_addr = '0; b0.cpu_req_row = 1'b0; b0.cpu_data_write = '0; b0.cpu_req_valid = 1'b0;
        b1.cpu_req_addr = '0; b1.cpu_req_row = 1'b0; b1.cpu_data_write = '0; b1.cpu_req_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = mem_init(8'(i));
            mem1[i] = mem_init(8'(i));
        end
        mem0[8'h25] = 32'hDEADBEEF;

        vecs[0] = '{8'h25, 1'b0, 32'h0,        32'hDEADBEEF,       1,  1, 1, 8'h00, 32'h0};
        vecs[1] = '{8'h25, 1'b0, 32'h0,        32'hDEADBEEF,       2,  1, 0, 8'h00, 32'h0};
        vecs[2] = '{8'h25, 1'b1, 32'h12345678, 32'hDEADBEEF,       3,  1, 0, 8'h00, 32'h0};
        vecs[3] = '{8'h45, 1'b0, 32'h0,        mem_init(8'h45),    4,  2, 1, 8'h00, 32'h0};
        vecs[4] = '{8'h65, 1'b0, 32'h0,        mem_init(8'h65),    5,  3, 2, 8'h25, 32'h12345678};
        vecs[5] = '{8'h45, 1'b0, 32'h0,        mem_init(8'h45),    6,  3, 0, 8'h00, 32'h0};
        vecs[6] = '{8'h25, 1'b0, 32'h0,        32'h12345678,       7,  4, 1, 8'h00, 32'h0};
        vecs[7] = '{8'h0A, 1'b1, 32'hCAFEF00D, 32'h12345678,       8,  5, 1, 8'h00, 32'h0};
        vecs[8] = '{8'h0A, 1'b0, 32'h0,        32'hCAFEF00D,       9,  5, 0, 8'h00, 32'h0};
        vecs[9] = '{8'h2A, 1'b0, 32'h0,        mem_init(8'h2A),    10, 6, 1, 8'h00, 32'h0};

        rstn0 = 1'b0;
        rstn1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", {31'b0, b0.cpu_ready}, 32'h0);
        chk("rst_mem_valid", {31'b0, b0.mem_req_valid}, 32'h0);
        chk("rst_mem_row", {31'b0, b0.mem_req_row}, 32'h0);
        chk("rst_mem_addr", {24'b0, b0.mem_req_addr}, 32'h0);
        chk("rst_cpu_data", b0.cpu_data_read, 32'h0);
        chk("rst_hits", {16'b0, hc0}, 32'h0);
        chk("rst_misses", {16'b0, mc0}, 32'h0);
        chk("rst1_mem_valid", {31'b0, b1.mem_req_valid}, 32'h0);
        rstn0 = 1'b1;
        rstn1 = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            log0.delete();
            do_req(0, vecs[i].addr, vecs[i].row, vecs[i].wdata, rd, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_hits", i), {16'b0, hc0}, vecs[i].exp_hits);
            chk($sformatf("v%0d_misses", i), {16'b0, mc0}, vecs[i].exp_miss);
            chk($sformatf("v%0d_mem_ops", i), log0.size(), vecs[i].exp_ops);
            if (vecs[i].exp_ops == 0) chk($sformatf("v%0d_hit_latency", i), lat, 2);
            if (vecs[i].exp_ops > 0 && log0.size() == vecs[i].exp_ops) begin
                chk($sformatf("v%0d_fill_addr", i), {24'b0, log0[log0.size()-1].addr}, {24'b0, vecs[i].addr});
                chk($sformatf("v%0d_fill_row", i), {31'b0, log0[log0.size()-1].row}, 32'h0);
                if (vecs[i].exp_ops == 2) begin
                    chk($sformatf("v%0d_wb_row", i), {31'b0, log0[0].row}, 32'h1);
                    chk($sformatf("v%0d_wb_addr", i), {24'b0, log0[0].addr}, {24'b0, vecs[i].wb_addr});
                    chk($sformatf("v%0d_wb_data", i), log0[0].data, vecs[i].wb_data);
                end
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready_pulse", i), {31'b0, b0.cpu_ready}, 32'h0);
        end

        // Reset while a dirty eviction of 0x0A is waiting on memory.
        hold0 = 1'b1;
        b0.cpu_req_addr = 8'h4A; b0.cpu_req_row = 1'b0; b0.cpu_data_write = '0; b0.cpu_req_valid = 1'b1;
        for (int k = 0; k < 20 && !b0.mem_req_valid; k++) begin
            @(posedge clk); #1;
            b0.cpu_req_valid = 1'b0;
        end
        chk("wb_valid_seen", {31'b0, b0.mem_req_valid}, 32'h1);
        chk("wb_row", {31'b0, b0.mem_req_row}, 32'h1);
        chk("wb_addr", {24'b0, b0.mem_req_addr}, 32'h0A);
        chk("wb_data", b0.mem_data_write, 32'hCAFEF00D);
        #2 rstn0 = 1'b0;
        #1;
        chk("midrst_mem_valid", {31'b0, b0.mem_req_valid}, 32'h0);
        chk("midrst_cpu_ready", {31'b0, b0.cpu_ready}, 32'h0);
        chk("midrst_hits", {16'b0, hc0}, 32'h0);
        chk("midrst_misses", {16'b0, mc0}, 32'h0);
        hold0 = 1'b0;
        @(posedge clk); #1;
        rstn0 = 1'b1;
        @(posedge clk); #1;
        log0.delete();
        do_req(0, 8'h25, 1'b0, 32'h0, rd, lat);
        chk("postrst_rdata", rd, 32'h12345678);
        chk("postrst_misses", {16'b0, mc0}, 32'h1);
        chk("postrst_hits", {16'b0, hc0}, 32'h1);
        chk("postrst_mem_ops", log0.size(), 32'h1);
        @(posedge clk); #1;

        // One-way instance: conflicting write-back then fill.
        log1.delete();
        do_req(1, 8'h03, 1'b1, 32'hA5A5A5A5, rd, lat);
        @(posedge clk); #1;
        do_req(1, 8'h13, 1'b0, 32'h0, rd, lat);
        chk("w1_rdata", rd, mem_init(8'h13));
        chk("w1_mem_ops", log1.size(), 32'h3);
        if (log1.size() == 3) begin
            chk("w1_fill03_addr", {24'b0, log1[0].addr}, 32'h03);
            chk("w1_wb_row", {31'b0, log1[1].row}, 32'h1);
            chk("w1_wb_addr", {24'b0, log1[1].addr}, 32'h03);
            chk("w1_wb_data", log1[1].data, 32'hA5A5A5A5);
            chk("w1_fill13_row", {31'b0, log1[2].row}, 32'h0);
            chk("w1_fill13_addr", {24'b0, log1[2].addr}, 32'h13);
        end
        chk("w1_hits", {16'b0, hc1}, 32'h2);
        chk("w1_misses", {16'b0, mc1}, 32'h2);
        @(posedge clk); #1;

        // Random traffic: a cache is transparent over a flat memory, with 2-entry LRU sets.
        rstn0 = 1'b0;
        @(posedge clk); #1;
        rstn0 = 1'b1;
        @(posedge clk); #1;
        begin
            logic [31:0] arch [256];
            bit          dirty [256];
            int          set_q [8][$];
            mop_t        exp_q [$];
            int          exp_h, exp_m, pos, tag, idx, vt;
            logic [7:0]  a, va;
            logic        row;
            logic [31:0] wd, exp_rd, last_rd;
            for (int i = 0; i < 256; i++) begin
                arch[i]  = mem0[i];
                dirty[i] = 1'b0;
            end
            exp_h   = 0;
            exp_m   = 0;
            last_rd = '0;
            for (int n = 0; n < 400; n++) begin
                idx = $urandom_range(0, 7);
                tag = $urandom_range(0, 3);
                a   = 8'(tag * 8 + idx);
                row = 1'($urandom_range(0, 1));
                wd  = $urandom;
                exp_q.delete();
                pos = -1;
                for (int j = 0; j < set_q[idx].size(); j++) if (set_q[idx][j] == tag) pos = j;
                if (pos < 0) begin
                    exp_m++;
                    if (set_q[idx].size() == 2) begin
                        vt = set_q[idx].pop_back();
                        va = 8'(vt * 8 + idx);
                        if (dirty[va]) exp_q.push_back('{va, 1'b1, arch[va]});
                        dirty[va] = 1'b0;
                    end
                    exp_q.push_back('{a, 1'b0, arch[a]});
                end else begin
                    set_q[idx].delete(pos);
                end
                set_q[idx].push_front(tag);
                exp_h++;
                if (!row) last_rd = arch[a];
                exp_rd = last_rd;
                if (row) begin
                    arch[a]  = wd;
                    dirty[a] = 1'b1;
                end
                log0.delete();
                do_req(0, a, row, wd, rd, lat);
                chk($sformatf("r%0d_rdata@%h", n, a), rd, exp_rd);
                chk($sformatf("r%0d_mem_ops", n), log0.size(), exp_q.size());
                if (log0.size() == exp_q.size()) begin
                    for (int j = 0; j < exp_q.size(); j++) begin
                        chk($sformatf("r%0d_op%0d_addr", n, j), {24'b0, log0[j].addr}, {24'b0, exp_q[j].addr});
                        chk($sformatf("r%0d_op%0d_row", n, j), {31'b0, log0[j].row}, {31'b0, exp_q[j].row});
                        chk($sformatf("r%0d_op%0d_data", n, j), log0[j].data, exp_q[j].data);
                    end
                end
                @(posedge clk); #1;
            end
            chk("rand_hits", {16'b0, hc0}, exp_h);
            chk("rand_misses", {16'b0, mc0}, exp_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
